// File: rtl/reg_file_sb.sv
// Dual-write, dual-read register file with a per-register busy scoreboard.
// Reads bypass same-cycle writes; issues mark a destination pending until written.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic              RSbusy_o,
    output logic              RTbusy_o,
    input  logic              RegWrite0_i,
    input  logic [ADDR_W-1:0] RDaddr0_i,
    input  logic [DATA_W-1:0] RDdata0_i,
    input  logic              RegWrite1_i,
    input  logic [ADDR_W-1:0] RDaddr1_i,
    input  logic [DATA_W-1:0] RDdata1_i,
    input  logic              Issue_i,
    input  logic [ADDR_W-1:0] IssueAddr_i,
    output logic              stall_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] data_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic              run_reg;

    logic we0, we1, iss;

    // run_reg stays low through reset and the edge that releases it, so that
    // edge cannot commit writes or issues and bypass is suppressed during reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) run_reg <= 1'b0;
        else        run_reg <= 1'b1;
    end

    assign we0 = run_reg && rst_i && RegWrite0_i && !(ZR && RDaddr0_i == '0);
    assign we1 = run_reg && rst_i && RegWrite1_i && !(ZR && RDaddr1_i == '0);
    assign iss = run_reg && rst_i && Issue_i     && !(ZR && IssueAddr_i == '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            logic hit0, hit1;
            assign hit0 = we0 && (RDaddr0_i == ADDR_W'(gi));
            assign hit1 = we1 && (RDaddr1_i == ADDR_W'(gi));

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i)    data_reg[gi] <= '0;
                else if (hit1) data_reg[gi] <= RDdata1_i;
                else if (hit0) data_reg[gi] <= RDdata0_i;
            end

            // A new issue supersedes a completing write to the same register.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i)                                  busy_reg[gi] <= 1'b0;
                else if (iss && IssueAddr_i == ADDR_W'(gi))  busy_reg[gi] <= 1'b1;
                else if (hit0 || hit1)                       busy_reg[gi] <= 1'b0;
            end
        end
    endgenerate

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    assign rd_addr[0] = RSaddr_i;
    assign rd_addr[1] = RTaddr_i;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic byp0, byp1, is_zero;
            assign byp0    = we0 && (RDaddr0_i == rd_addr[gi]);
            assign byp1    = we1 && (RDaddr1_i == rd_addr[gi]);
            assign is_zero = ZR && (rd_addr[gi] == '0);

            always_comb begin
                rd_data[gi] = data_reg[rd_addr[gi]];
                if (byp1)      rd_data[gi] = RDdata1_i;
                else if (byp0) rd_data[gi] = RDdata0_i;
                if (is_zero)   rd_data[gi] = '0;
                rd_busy[gi] = busy_reg[rd_addr[gi]] && !(byp0 || byp1) && !is_zero;
            end
        end
    endgenerate

    assign RSdata_o = rd_data[0];
    assign RTdata_o = rd_data[1];
    assign RSbusy_o = rd_busy[0];
    assign RTbusy_o = rd_busy[1];
    assign stall_o  = rd_busy[0] | rd_busy[1];

endmodule
